// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - arb_state_e       : arbiter FSM state encodings
//   - DMEM_ARB_MAX_WAIT : default host starvation bound
//   - cnt_width()       : bits needed to hold 0..max
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WAIT = 2'd1,  // host pending but denied
        ARB_ACK  = 2'd2   // ack cycle; host request ignored
    } arb_state_e;

    localparam int DMEM_ARB_MAX_WAIT = 8;

    function automatic int cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle around the data-memory arbiter: CPU load/store path,
// host/debug req/ack port, and the single data-memory port.
//   slave  : arbiter view (takes cpu_*/host_* commands, drives mem_*)
//   master : environment view (CPU, host and memory side)
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU pipeline side
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    // Host/debug side
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;
    // Data memory side
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over inc).
// Ports: clk, reset_n (async, active-low), inc, clr, cnt (0..MAX).
module dmem_arbiter_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != WIDTH'(MAX))) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU load/store path (priority,
// zero-latency combinational path) and a host/debug req/ack port with a
// starvation bound that forces a host grant, stalling the CPU one cycle.
// Ports:
//   clk, reset_n           : core clock, async active-low reset
//   bus (slave)            : cpu_*, host_*, mem_* signal bundle
//   stat_host_grants       : host accesses served (wrapping)
//   stat_cpu_stall_cycles  : cycles with cpu_stall=1 (wrapping)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = DMEM_ARB_MAX_WAIT,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    dmem_arbiter_if.slave    bus,
    output logic [CNT_W-1:0] stat_host_grants,
    output logic [CNT_W-1:0] stat_cpu_stall_cycles
);

    localparam int WAIT_W = cnt_width(MAX_WAIT);

    arb_state_e        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_max;
    logic              host_grant;
    logic              host_denied;
    logic              cpu_stall_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] host_rdata_q;
    logic              host_ack_q;

    // Shared grant decode; the host is never eligible in its ack cycle.
    assign wait_max    = (wait_cnt == WAIT_W'(MAX_WAIT));
    assign host_grant  = bus.host_req && (state != ARB_ACK) && (!bus.cpu_req || wait_max);
    assign host_denied = bus.host_req && (state != ARB_ACK) && !host_grant;

    dmem_arbiter_sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (host_denied),
        .clr     (host_grant || !bus.host_req),
        .cnt     (wait_cnt)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ARB_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt
        // unassigned, which would otherwise infer a latch.
        state_nxt = ARB_IDLE;
        unique case (state)
            ARB_IDLE: begin
                if (host_grant)        state_nxt = ARB_ACK;
                else if (bus.host_req) state_nxt = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (host_grant)        state_nxt = ARB_ACK;
                else if (bus.host_req) state_nxt = ARB_WAIT;
                // host_req dropped while waiting: abandon without ack
            end
            ARB_ACK:  state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Output logic: memory port mux and CPU stall
    always_comb begin
        cpu_stall_c = bus.cpu_req && host_grant;
        mem_we_c    = bus.cpu_req && bus.cpu_we;
        mem_addr_c  = bus.cpu_addr;
        mem_wdata_c = bus.cpu_wdata;
        if (host_grant) begin
            mem_we_c    = bus.host_we;
            mem_addr_c  = bus.host_addr;
            mem_wdata_c = bus.host_wdata;
        end
    end

    assign bus.cpu_stall  = cpu_stall_c;
    assign bus.cpu_rdata  = bus.mem_rdata;
    assign bus.mem_we     = mem_we_c;
    assign bus.mem_addr   = mem_addr_c;
    assign bus.mem_wdata  = mem_wdata_c;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;

    // Host completion: capture read data on the grant cycle, ack one later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            host_ack_q <= host_grant;
            if (host_grant && !bus.host_we) host_rdata_q <= bus.mem_rdata;
        end
    end

    // Statistics, wrapping modulo 2^CNT_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_host_grants      <= '0;
            stat_cpu_stall_cycles <= '0;
        end else begin
            if (host_grant)  stat_host_grants      <= stat_host_grants + CNT_W'(1);
            if (cpu_stall_c) stat_cpu_stall_cycles <= stat_cpu_stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the CPU pipeline's load/store path and a host/debug access port (preloading, result dump). The arbiter sits between `cpu_pipeline`/host and `data_memory` inside the core wrapper. The CPU has priority and a combinational zero-latency path. The host uses a req/ack handshake with a starvation bound that forces a grant and stalls the CPU for one cycle. Grant and stall statistics are exported alongside the existing `stat_*` counters.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 8, host denied-cycle threshold before a forced grant (≥1)
- `CNT_W`, 32, statistics counter width
- `clk`  in  1  core clock
- `reset_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `cpu_req`  in  1  CPU memory access this cycle
- `cpu_we`  in  1  CPU store
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_rdata`  out  DATA_W  load data (= `mem_rdata`, combinational)
- `cpu_stall`  out  1  CPU request not served this cycle
- `host_req`  in  1  host request, held until `host_ack`
- `host_we`, `host_addr`, `host_wdata`  in  1/ADDR_W/DATA_W  host command, stable while `host_req`=1
- `host_ack`  out  1  one-cycle completion pulse (registered)
- `host_rdata`  out  DATA_W  read data, valid with `host_ack`, held until next ack
- `mem_we`, `mem_addr`, `mem_wdata`  out  1/ADDR_W/DATA_W  to `data_memory`
- `mem_rdata`  in  DATA_W  async read data from `data_memory`
- `stat_host_grants`  out  CNT_W  host accesses served
- `stat_cpu_stall_cycles`  out  CNT_W  cycles with `cpu_stall`=1

## Operation
- States: IDLE, WAIT (host pending, denied), ACK (ack cycle; host ignored).
- `host_grant` = `host_req` & state≠ACK & (!`cpu_req` | `wait_cnt`==MAX_WAIT).
- `cpu_stall` = `cpu_req` & `host_grant`.
- If `host_grant` is set, `mem_*` carry the `host_*` command. Otherwise `mem_*` carry the `cpu_*` command, with `mem_we` = `cpu_req` & `cpu_we`.
- `mem_we` is never 1 unless the granted requester is writing. When idle, `mem_addr` = `cpu_addr`.
- Transitions:
  - IDLE or WAIT with `host_grant` → ACK.
  - IDLE with `host_req` denied → WAIT.
  - WAIT with `host_req`=0 (protocol violation) → IDLE, no ack.
  - ACK → IDLE always.
- `wait_cnt`: +1 per denied cycle in WAIT or IDLE, saturating at MAX_WAIT. Cleared on grant or when `host_req`=0.
- On grant: `host_rdata` ← `mem_rdata` (reads only; writes leave it unchanged), and `host_ack` =1 next cycle.
- Back-to-back: the host may hold `host_req` through ACK for a new command. That command is eligible the cycle after ACK. Peak host throughput is one access per 2 cycles.
- Stats increment by 1 per event and wrap modulo 2^CNT_W.

## Timing
- Reset (async, `reset_n`=0): state IDLE, `wait_cnt`=0, `host_ack`=0, `host_rdata`=0, both stats 0. Combinational outputs follow inputs: `cpu_stall`=0 since state is IDLE and `wait_cnt`=0.
- CPU path latency is 0 cycles: combinational `cpu_rdata`/`cpu_stall`.
- Host worst-case grant is MAX_WAIT+1 cycles after `host_req` rises, and `host_ack` comes 1 cycle after grant. With `cpu_req` held high, `cpu_stall` pulses exactly once per forced grant.
- Simultaneous `cpu_req` and `host_req` with `wait_cnt`<MAX_WAIT: the CPU is served, and the host moves to or stays in WAIT.
- Reset mid-transaction: the pending host access is dropped with no ack. A `host_req` still high after reset release is treated as a new request.
- A host write in the same cycle as a CPU read of the same address cannot occur, because there is one port per cycle.

## Structure
- Shared core defines header holds the state encodings (`ARB_IDLE`=2'd0, `ARB_WAIT`=2'd1, `ARB_ACK`=2'd2) and the `DMEM_ARB_MAX_WAIT` default.
- Sub-module `sat_counter` (width, max; inc/clr) implements `wait_cnt`. Stats use plain wrapping counters inline.

## Test plan
- CPU-only: `cpu_req`=1 store 0xA5 to addr 0x10, then load → `mem_we`=1 on the store, `cpu_rdata`=0xA5, `cpu_stall`=0 always, stats stay 0.
- Host-only read: `host_req`=1 at cycle 0 for addr 0x10 → grant at cycle 0, `host_ack`=1 at cycle 1, `host_rdata`=0xA5, `stat_host_grants`=1.
- Starvation, MAX_WAIT=8: `cpu_req`=1 continuously, host write 0x5A@0x20 at cycle 0 → host granted at cycle 8 with `cpu_stall`=1 only in cycle 8, ack at cycle 9, `stat_cpu_stall_cycles`=1.
- Back-to-back: host holds `host_req` for 3 commands, CPU idle → acks at cycles 1, 3, 5, and no grant in any ACK cycle.
- Abort: host drops `host_req` in WAIT at `wait_cnt`=3 → IDLE, `wait_cnt`=0, no ack, no `mem_we` from host.
- Reset mid-op: assert `reset_n`=0 in ACK → `host_ack`=0 immediately, all outputs at reset values, stats 0.
